// File: rtl/ysyx_25040111_imem_resp.sv
// Instruction-memory responder for the fetch handshake, backed by a word array with a side loader port.
// Define IMEM_RAND_DELAY_EN to add 0..7 LFSR-driven extra cycles of latency per request.
module ysyx_25040111_imem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_inst,
  output logic        acc_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH);
`ifdef IMEM_RAND_DELAY_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          enter_resp;
  logic [CW-1:0] lat_total;
  logic [31:0]   rd_word_q;
  logic          rd_ok_q;
  logic          err_q;
  logic          rd_ok;
  logic [AW-1:0] rd_idx;
  logic          ld_ok;
  logic [AW-1:0] ld_idx;
  logic [31:0]   mem [DEPTH];

  // Bounds are compared in 33 bits so BASE_ADDR + 4*DEPTH cannot wrap.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} >= LO_ADDR) && ({1'b0, a} < HI_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'(({1'b0, a} - LO_ADDR) >> 2);
  endfunction

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign lat_total = CW'(LATENCY) + CW'(lfsr_q[2:0]);
`else
  assign lat_total = CW'(LATENCY);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifu_valid) begin
          req_addr_d = ifu_addr;
          if (lat_total == CW'(1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = lat_total - CW'(2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!ifu_valid) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_addr_d is the live address on a direct IDLE->RESP jump and the latched one otherwise.
  assign rd_ok  = addr_ok(req_addr_d);
  assign rd_idx = word_idx(req_addr_d);
  assign ld_ok  = ld_en && addr_ok(ld_addr);
  assign ld_idx = word_idx(ld_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      rd_ok_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      if (enter_resp) begin
        rd_ok_q <= rd_ok;
        err_q   <= !rd_ok;
      end
    end
  end

  // Read and write share one block so a same-cycle write to the read word returns the old data.
  always_ff @(posedge clock) begin
    if (enter_resp) rd_word_q <= mem[rd_idx];
    if (ld_ok)      mem[ld_idx] <= ld_data;
  end

  assign ifu_ready = (state_q == RESP) && ifu_valid;
  assign ifu_inst  = rd_ok_q ? rd_word_q : 32'h0;
  assign acc_err   = err_q && ifu_ready;

endmodule
